// File: rtl/mem_op_responder.sv
// Memory-side responder: executes one memory-op command at a time against a local word store.
// Optional AMO execution is built only when MEM_RESP_AMO_EN is defined.
module mem_op_responder #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_cmd,
  input  logic [31:0]      req_addr,
  input  logic [63:0]      req_data,
  input  logic [7:0]       req_mask,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_data,
  output logic             resp_has_data,
  output logic             resp_err,
  output logic [TAG_W-1:0] resp_tag
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [4:0] M_XRD       = 5'b00000;
  localparam logic [4:0] M_XWR       = 5'b00001;
  localparam logic [4:0] M_PFR       = 5'b00010;
  localparam logic [4:0] M_PFW       = 5'b00011;
  localparam logic [4:0] M_XA_SWAP   = 5'b00100;
  localparam logic [4:0] M_FLUSH_ALL = 5'b00101;
  localparam logic [4:0] M_XLR       = 5'b00110;
  localparam logic [4:0] M_XSC       = 5'b00111;
  localparam logic [4:0] M_XA_ADD    = 5'b01000;
  localparam logic [4:0] M_XA_XOR    = 5'b01001;
  localparam logic [4:0] M_XA_OR     = 5'b01010;
  localparam logic [4:0] M_XA_AND    = 5'b01011;
  localparam logic [4:0] M_XA_MIN    = 5'b01100;
  localparam logic [4:0] M_XA_MAX    = 5'b01101;
  localparam logic [4:0] M_XA_MINU   = 5'b01110;
  localparam logic [4:0] M_XA_MAXU   = 5'b01111;
  localparam logic [4:0] M_FLUSH     = 5'b10000;
  localparam logic [4:0] M_PWR       = 5'b10001;
  localparam logic [4:0] M_PRODUCE   = 5'b10010;
  localparam logic [4:0] M_CLEAN     = 5'b10011;
  localparam logic [4:0] M_SFENCE    = 5'b10100;
  localparam logic [4:0] M_WOK       = 5'b10111;

  typedef enum logic [1:0] {IDLE, AMO, FLUSH, RESP} state_t;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w, input logic [63:0] new_w,
                                               input logic [7:0] mask);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction

`ifdef MEM_RESP_AMO_EN
  function automatic logic [63:0] amo_alu(input logic [4:0] cmd, input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = a;
    sb = b;
    case (cmd)
      M_XA_ADD:  return a + b;
      M_XA_XOR:  return a ^ b;
      M_XA_OR:   return a | b;
      M_XA_AND:  return a & b;
      M_XA_MIN:  return (sa < sb) ? a : b;
      M_XA_MAX:  return (sa > sb) ? a : b;
      M_XA_MINU: return (a < b) ? a : b;
      M_XA_MAXU: return (a > b) ? a : b;
      default:   return b;
    endcase
  endfunction

  logic [4:0]    op_cmd_p1;
  logic [63:0]   op_data_p1;
`endif

  state_t          state;
  logic [63:0]     mem [DEPTH];
  logic [DEPTH-1:0] dirty;
  logic            res_vld;
  logic [AW-1:0]   res_idx;
  logic [AW-1:0]   op_idx_p1;
  logic [AW-1:0]   fidx;
  logic [AW:0]     fcnt;

  // Accept stage: decode the word index and current contents
  logic            accept;
  logic [AW-1:0]   idx_p0;
  logic [63:0]     word_p0;
  logic            res_hit_p0;
  logic            unused_addr;

  assign accept      = req_valid && req_ready;
  assign idx_p0      = req_addr[3 +: AW];
  assign word_p0     = mem[idx_p0];
  assign res_hit_p0  = res_vld && (res_idx == idx_p0);
  assign unused_addr = ^{req_addr[31:3+AW], req_addr[2:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_has_data <= 1'b0;
      resp_err      <= 1'b0;
      resp_tag      <= '0;
      dirty         <= '0;
      res_vld       <= 1'b0;
      res_idx       <= '0;
      op_idx_p1     <= '0;
      fidx          <= '0;
      fcnt          <= '0;
`ifdef MEM_RESP_AMO_EN
      op_cmd_p1     <= '0;
      op_data_p1    <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready     <= 1'b0;
            resp_valid    <= 1'b1;
            resp_tag      <= req_tag;
            resp_data     <= '0;
            resp_has_data <= 1'b0;
            resp_err      <= 1'b0;
            state         <= RESP;
            case (req_cmd)
              M_XRD: begin
                resp_data     <= word_p0;
                resp_has_data <= 1'b1;
              end
              M_XWR: begin
                mem[idx_p0]   <= req_data;
                dirty[idx_p0] <= 1'b1;
                if (res_hit_p0) res_vld <= 1'b0;
              end
              M_PWR: begin
                if (|req_mask) begin
                  mem[idx_p0]   <= merge_bytes(word_p0, req_data, req_mask);
                  dirty[idx_p0] <= 1'b1;
                  if (res_hit_p0) res_vld <= 1'b0;
                end
              end
              M_XLR: begin
                resp_data     <= word_p0;
                resp_has_data <= 1'b1;
                res_vld       <= 1'b1;
                res_idx       <= idx_p0;
              end
              M_XSC: begin
                resp_has_data <= 1'b1;
                res_vld       <= 1'b0;
                if (res_hit_p0) begin
                  mem[idx_p0]   <= req_data;
                  dirty[idx_p0] <= 1'b1;
                end else begin
                  resp_data <= 64'd1;
                end
              end
`ifdef MEM_RESP_AMO_EN
              M_XA_SWAP, M_XA_ADD, M_XA_XOR, M_XA_OR, M_XA_AND,
              M_XA_MIN, M_XA_MAX, M_XA_MINU, M_XA_MAXU: begin
                resp_data     <= word_p0;
                resp_has_data <= 1'b1;
                resp_valid    <= 1'b0;
                op_cmd_p1     <= req_cmd;
                op_data_p1    <= req_data;
                op_idx_p1     <= idx_p0;
                state         <= AMO;
              end
`endif
              M_FLUSH_ALL: begin
                resp_has_data <= 1'b1;
                resp_valid    <= 1'b0;
                res_vld       <= 1'b0;
                fidx          <= '0;
                fcnt          <= '0;
                state         <= FLUSH;
              end
              M_PFR, M_PFW, M_FLUSH, M_PRODUCE, M_CLEAN, M_SFENCE, M_WOK: ;
              default: resp_err <= 1'b1;
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end
`ifdef MEM_RESP_AMO_EN
        // Execute stage: resp_data already holds the old value
        AMO: begin
          mem[op_idx_p1]   <= amo_alu(op_cmd_p1, resp_data, op_data_p1);
          dirty[op_idx_p1] <= 1'b1;
          if (res_vld && (res_idx == op_idx_p1)) res_vld <= 1'b0;
          resp_valid       <= 1'b1;
          state            <= RESP;
        end
`endif
        FLUSH: begin
          dirty[fidx] <= 1'b0;
          if (fidx == AW'(DEPTH - 1)) begin
            resp_data  <= 64'(fcnt + (AW+1)'(dirty[fidx]));
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            fcnt <= fcnt + (AW+1)'(dirty[fidx]);
            fidx <= fidx + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_op_responder.md
# mem_op_responder

- Target side of the memory-op command encoding used by the core/cache request path.
- Accepts one command at a time over a valid/ready request channel and executes it against a small local word store.
- Stores support loads, full and masked stores, LR/SC, AMOs and FLUSH_ALL.
- Returns a tagged response over a valid/ready response channel.
- Serves as the memory-side model and scratchpad responder behind the L1 request port.

## Interface
Parameters:
- DEPTH, 16, number of 64-bit words; power of two, ≥2.
- TAG_W, 6, width of request/response tag.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_cmd  in  5  memory-op command code.
- req_addr  in  32  byte address; word index = req_addr[3 +: log2(DEPTH)]; other bits ignored.
- req_data  in  64  store/AMO/SC operand.
- req_mask  in  8  byte enables; used by M_PWR only.
- req_tag  in  TAG_W  echoed on response.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  64  load data, AMO old value, SC status, or FLUSH_ALL dirty count.
- resp_has_data  out  1  resp_data meaningful.
- resp_err  out  1  command unsupported or undefined.
- resp_tag  out  TAG_W  tag of the request.

## Operation
- FSM states: IDLE, AMO, FLUSH, RESP.
- One request outstanding at a time. Every command produces exactly one response.
- Storage: DEPTH×64 words plus one dirty bit per word. All words, all dirty bits and the reservation are 0 after reset.
- Per-command behaviour (writes to storage occur on the accept edge unless stated):
  - M_XRD: resp_data = word.
  - M_XWR: full-word write; sets dirty.
  - M_PWR: write bytes where req_mask[i]=1; sets dirty. Mask 0 writes nothing and leaves dirty unchanged.
  - M_XLR: resp_data = word; reservation ← {valid=1, index}.
  - M_XSC:
    - Success when reservation is valid and its index matches: write word, set dirty, resp_data=0.
    - Otherwise no write, resp_data=1.
    - Reservation cleared in both cases.
  - AMOs (SWAP, ADD, XOR, OR, AND, MIN, MAX, MINU, MAXU):
    - 64-bit full-word operations. ADD wraps mod 2^64. MIN/MAX compare signed; MINU/MAXU compare unsigned.
    - Accept edge latches the old value. The AMO state writes op(old, req_data) and sets dirty.
    - resp_data = old value.
  - M_FLUSH_ALL: FLUSH state walks indices 0..DEPTH-1, one per cycle, clearing dirty bits. resp_data = number of dirty words found (zero-extended).
  - M_PFR, M_PFW, M_FLUSH, M_PRODUCE, M_CLEAN, M_SFENCE, M_WOK: no state change; resp_has_data=0, resp_err=0.
  - Undefined codes (10101, 10110, 11000–11111): no state change; resp_err=1, resp_has_data=0.
- resp_has_data=1 for XRD, XLR, XSC, AMO and FLUSH_ALL; 0 otherwise.
- Reservation is cleared by:
  - any successful write (XWR, PWR with nonzero mask, AMO, SC) to the reserved index;
  - any SC;
  - FLUSH_ALL;
  - reset.
- A second LR overwrites the reservation.

## Timing
- Accept occurs when req_valid && req_ready.
- Response latency from accept in cycle N:
  - Simple commands: resp_valid in cycle N+1.
  - AMO: write in cycle N+1, resp_valid in N+2.
  - FLUSH_ALL: resp_valid in N+1+DEPTH.
- RESP holds resp_* stable until resp_valid && resp_ready. The FSM returns to IDLE on that edge, and req_ready rises the following cycle. There is no same-cycle turnaround.
- Load data reflects all earlier accepted writes. A read issued immediately after a write sees the new data.
- Reset values: req_ready=0 during reset and 1 after release. resp_valid, resp_data, resp_has_data, resp_err and resp_tag are all 0.
- Reset asserted mid-AMO or mid-FLUSH:
  - Operation abandoned; no response issued.
  - Storage, dirty bits and reservation all return to reset values.

## Configuration
- MEM_RESP_AMO_EN defined: AMO commands execute as above.
- MEM_RESP_AMO_EN undefined:
  - AMO codes are treated as undefined: resp_err=1 in N+1, no storage change.
  - The AMO state and ALU are not built.
  - LR/SC are unaffected.

## Test plan
- After reset, XWR addr 0x08 data 0xDEAD_BEEF_0123_4567, then XRD addr 0x08 -> resp_data 0xDEAD_BEEF_0123_4567, resp_has_data=1, tag echoed.
- PWR addr 0x10 data 0xFFFF_FFFF_FFFF_FFFF mask 0x0F onto zero word -> XRD returns 0x0000_0000_FFFF_FFFF.
- LR addr 0x18, SC addr 0x18 data 5 -> resp_data 0. Second SC -> resp_data 1, word stays 5. LR, XWR to same index, SC -> resp_data 1.
- AMO_MIN on word 0x7FFF_FFFF_FFFF_FFFF with operand 0x8000_0000_0000_0000 -> resp_data 0x7FFF…, word becomes 0x8000…, resp_valid exactly 2 cycles after accept. Without MEM_RESP_AMO_EN -> resp_err=1, word unchanged.
- Dirty 3 words, then FLUSH_ALL with DEPTH=16 -> resp_data 3 in cycle N+17. Second FLUSH_ALL -> resp_data 0.
- Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0. Send cmd 5'b11010 -> resp_err=1. Assert reset mid-FLUSH -> resp_valid=0 and storage zeroed.
